// File: rtl/lsu_ctrl_pkg.sv
// Shared encodings for the load/store unit: memory opcodes, FSM states, byte-enable patterns.
// The helpers classify an opcode by its access size and by its direction.
package lsu_ctrl_pkg;

    localparam logic [3:0] MEM_NOP = 4'd0;
    localparam logic [3:0] MEM_LB  = 4'd1;
    localparam logic [3:0] MEM_LH  = 4'd2;
    localparam logic [3:0] MEM_LW  = 4'd3;
    localparam logic [3:0] MEM_SB  = 4'd4;
    localparam logic [3:0] MEM_SH  = 4'd5;
    localparam logic [3:0] MEM_SW  = 4'd6;

    localparam logic [1:0] LSU_IDLE = 2'd0;
    localparam logic [1:0] LSU_REQ  = 2'd1;
    localparam logic [1:0] LSU_WAIT = 2'd2;
    localparam logic [1:0] LSU_RESP = 2'd3;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        SIZE_NONE,
        SIZE_BYTE,
        SIZE_HALF,
        SIZE_WORD
    } accSize_t;

    // Undefined opcodes fall through to SIZE_NONE and so behave like MEM_NOP.
    function automatic accSize_t opSize(input logic [3:0] op);
        case (op)
            MEM_LB, MEM_SB: return SIZE_BYTE;
            MEM_LH, MEM_SH: return SIZE_HALF;
            MEM_LW, MEM_SW: return SIZE_WORD;
            default:        return SIZE_NONE;
        endcase
    endfunction

    function automatic logic isStore(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic isValidOp(input logic [3:0] op);
        return opSize(op) != SIZE_NONE;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables, replicated store data, alignment
// check and sign-extended load data for a 32-bit data bus.
module lsu_align
    import lsu_ctrl_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o,
    output logic [31:0] rdataExt_o
);

    accSize_t    size;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        size       = opSize(op_i);
        be_o       = BE_WORD;
        wdata_o    = data_i;
        misalign_o = 1'b0;
        rdataExt_o = rdata_i;
        byteSel    = rdata_i[7:0];
        halfSel    = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (off_i)
            2'd0:    byteSel = rdata_i[7:0];
            2'd1:    byteSel = rdata_i[15:8];
            2'd2:    byteSel = rdata_i[23:16];
            default: byteSel = rdata_i[31:24];
        endcase

        // Byte accesses can never be misaligned; halves need an even offset, words a zero offset.
        case (size)
            SIZE_BYTE: begin
                be_o       = BE_BYTE << off_i;
                wdata_o    = {4{data_i[7:0]}};
                rdataExt_o = {{24{byteSel[7]}}, byteSel};
            end
            SIZE_HALF: begin
                be_o       = off_i[1] ? {BE_HALF[1:0], 2'b00} : BE_HALF;
                wdata_o    = {2{data_i[15:0]}};
                misalign_o = off_i[0];
                rdataExt_o = {{16{halfSel[15]}}, halfSel};
            end
            SIZE_WORD: begin
                misalign_o = (off_i != 2'b00);
            end
            default: begin
                misalign_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: accepts one memory op at a time, runs the req/gnt/rvalid
// handshake on the data bus and returns sign-extended load data to the register file.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int REGADDR_W = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [3:0]           mem_op_i,
    input  logic [ADDR_W-1:0]    mem_addr_i,
    input  logic [DATA_W-1:0]    mem_data_i,
    input  logic                 mem_we_i,
    input  logic [REGADDR_W-1:0] reg_waddr_i,
    output logic                 stall_o,
    output logic [DATA_W-1:0]    reg_wdata_o,
    output logic                 reg_we_o,
    output logic [REGADDR_W-1:0] reg_waddr_o,
    output logic                 misalign_o,
    output logic                 bus_req_o,
    output logic                 bus_we_o,
    output logic [ADDR_W-1:0]    bus_addr_o,
    output logic [3:0]           bus_be_o,
    output logic [DATA_W-1:0]    bus_wdata_o,
    input  logic                 bus_gnt_i,
    input  logic                 bus_rvalid_i,
    input  logic [DATA_W-1:0]    bus_rdata_i
);

    logic [1:0]           state_q, state_d;
    logic [3:0]           op_q, op_d;
    logic [1:0]           off_q, off_d;
    logic                 busReq_q, busReq_d;
    logic                 busWe_q, busWe_d;
    logic [ADDR_W-1:0]    busAddr_q, busAddr_d;
    logic [3:0]           busBe_q, busBe_d;
    logic [DATA_W-1:0]    busWdata_q, busWdata_d;
    logic [DATA_W-1:0]    regWdata_q, regWdata_d;
    logic                 regWe_q, regWe_d;
    logic [REGADDR_W-1:0] regWaddr_q, regWaddr_d;
    logic                 misalign_q, misalign_d;

    logic        validOp;
    logic        weBad;
    logic [3:0]  alignOp;
    logic [1:0]  alignOff;
    logic [3:0]  alignBe;
    logic [31:0] alignWdata;
    logic        alignMis;
    logic [31:0] alignExt;

    assign validOp = isValidOp(mem_op_i);
    assign weBad   = (isStore(mem_op_i) != mem_we_i);

    // The aligner sees the incoming op while idle and the latched op afterwards,
    // so one instance serves both store steering and load extension.
    assign alignOp  = (state_q == LSU_IDLE) ? mem_op_i : op_q;
    assign alignOff = (state_q == LSU_IDLE) ? mem_addr_i[1:0] : off_q;

    lsu_align u_align (
        .op_i       (alignOp),
        .off_i      (alignOff),
        .data_i     (mem_data_i),
        .rdata_i    (bus_rdata_i),
        .be_o       (alignBe),
        .wdata_o    (alignWdata),
        .misalign_o (alignMis),
        .rdataExt_o (alignExt)
    );

    assign stall_o = (state_q == LSU_REQ) || (state_q == LSU_WAIT) ||
                     ((state_q == LSU_IDLE) && validOp && !rst_i);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        off_d      = off_q;
        busReq_d   = busReq_q;
        busWe_d    = busWe_q;
        busAddr_d  = busAddr_q;
        busBe_d    = busBe_q;
        busWdata_d = busWdata_q;
        regWdata_d = regWdata_q;
        regWe_d    = regWe_q;
        regWaddr_d = regWaddr_q;
        misalign_d = misalign_q;

        case (state_q)
            LSU_IDLE: begin
                regWe_d    = 1'b0;
                misalign_d = 1'b0;
                if (validOp) begin
                    op_d       = mem_op_i;
                    off_d      = mem_addr_i[1:0];
                    regWaddr_d = reg_waddr_i;
                    // Illegal accesses (misaligned or wrong we) skip the bus entirely.
                    if (alignMis || weBad) begin
                        misalign_d = 1'b1;
                        state_d    = LSU_RESP;
                    end else begin
                        busReq_d   = 1'b1;
                        busWe_d    = isStore(mem_op_i);
                        busAddr_d  = {mem_addr_i[ADDR_W-1:2], 2'b00};
                        busBe_d    = alignBe;
                        busWdata_d = alignWdata;
                        state_d    = LSU_REQ;
                    end
                end
            end
            LSU_REQ: begin
                if (bus_gnt_i) begin
                    busReq_d = 1'b0;
                    state_d  = isStore(op_q) ? LSU_RESP : LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                if (bus_rvalid_i) begin
                    regWdata_d = alignExt;
                    regWe_d    = 1'b1;
                    state_d    = LSU_RESP;
                end
            end
            default: begin
                regWe_d    = 1'b0;
                misalign_d = 1'b0;
                state_d    = LSU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= LSU_IDLE;
            op_q       <= MEM_NOP;
            off_q      <= '0;
            busReq_q   <= 1'b0;
            busWe_q    <= 1'b0;
            busAddr_q  <= '0;
            busBe_q    <= '0;
            busWdata_q <= '0;
            regWdata_q <= '0;
            regWe_q    <= 1'b0;
            regWaddr_q <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            off_q      <= off_d;
            busReq_q   <= busReq_d;
            busWe_q    <= busWe_d;
            busAddr_q  <= busAddr_d;
            busBe_q    <= busBe_d;
            busWdata_q <= busWdata_d;
            regWdata_q <= regWdata_d;
            regWe_q    <= regWe_d;
            regWaddr_q <= regWaddr_d;
            misalign_q <= misalign_d;
        end
    end

    assign reg_wdata_o = regWdata_q;
    assign reg_we_o    = regWe_q;
    assign reg_waddr_o = regWaddr_q;
    assign misalign_o  = misalign_q;
    assign bus_req_o   = busReq_q;
    assign bus_we_o    = busWe_q;
    assign bus_addr_o  = busAddr_q;
    assign bus_be_o    = busBe_q;
    assign bus_wdata_o = busWdata_q;

endmodule
